shift_right_iterative: RTL
==========================

Name: shift_right_iterative

Overview:
- Multi-cycle right shifter for the ALU datapath; the complement of the combinational left shifter.
- Supports logical (SRL) and arithmetic (SRA) right shifts, one bit position per clock.
- Takes operands through a valid/ready input handshake and returns the result through a valid/ready output handshake.
- Used where area matters more than latency, replacing a 32-way mux bank per bit.

Parameters:
- N, 32, data width; only N=32 is required to be supported. Shift amount width is $clog2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept an operand this cycle.
- in  input  N  value to shift.
- shamt  input  $clog2(N)  shift amount, 0..N-1.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result this cycle.
- out  output  N  shift result, registered.

Behaviour:
- Reset: rst is sampled only on the rising clk edge.
  - State goes to IDLE; out=0, out_valid=0, in_ready=1.
  - Internal count is cleared and the latched arith is cleared.
  - rst overrides all other inputs, including mid-SHIFT and during DONE; any in-flight operation is discarded without producing a result.
- States: IDLE, SHIFT, DONE (2-bit encoded).
- Accept: an operand is accepted on any edge where in_valid && in_ready. On accept:
  - data register <= in, count <= shamt, mode <= arith.
  - Next state is SHIFT if shamt != 0, else DONE.
- IDLE: in_ready=1, out_valid=0.
- SHIFT: in_ready=0, out_valid=0. Each edge:
  - data <= {fill, data[N-1:1]}, where fill = mode ? data[N-1] : 1'b0.
  - count <= count - 1.
  - When count==1 on that edge, next state is DONE.
- DONE: out_valid=1 and out = data, held stable while out_ready=0.
  - in_ready = out_ready.
  - If out_ready && !in_valid: next state IDLE.
  - If out_ready && in_valid: the result handoff and a new accept happen on the same edge; the next state follows the accept rule (back-to-back operation, no idle bubble).
- out is the data register; it is driven continuously but is only meaningful while out_valid=1.
- in, shamt and arith are ignored unless accepted. Operand changes after accept do not affect the result.
- Latency: out_valid rises in the cycle after edge k+shamt, where k is the accept edge. shamt=0 gives 1 cycle; shamt=31 gives 32 cycles.
- Throughput: one result per shamt+1 cycles when out_ready is held high.
- Arithmetic:
  - Result equals in >> shamt (SRL) or $signed(in) >>> shamt (SRA).
  - No overflow is possible.
  - count never underflows, because SHIFT is entered only with count >= 1.
- Protocol invariant: in_ready and out_valid are never both 1 except in DONE.

Test Plan:
- Assert rst for 2 cycles, then deassert -> out=0x00000000, out_valid=0, in_ready=1. Repeat with in_valid=1 held during rst -> nothing is accepted.
- in=0x80000000, shamt=4, arith=0, out_ready=1 -> out_valid rises 5 cycles after the accept cycle, out=0x08000000, exactly one out_valid cycle. Repeat with arith=1 -> out=0xF8000000.
- in=0x12345678, shamt=0 -> out=0x12345678 with out_valid in the cycle after accept. in=0xFFFFFFFF, shamt=31 -> 32-cycle latency; out=0x00000001 for arith=0, out=0xFFFFFFFF for arith=1.
- Backpressure: complete in=0xA5A5A5A5, shamt=8, arith=1 with out_ready=0 for 10 cycles -> out=0xFFA5A5A5 held stable and in_ready=0 throughout. Then raise out_ready with in_valid=1, in=0x00000010, shamt=1, arith=0 -> new operand accepted on the same edge, next out=0x00000008 two cycles later.
- Reset mid-operation: accept shamt=20, assert rst on the 3rd SHIFT cycle -> next cycle is IDLE, out_valid=0, in_ready=1, and no result is ever emitted for that operand.
- Random regression: 1000 random (in, shamt, arith) with random out_ready stalls -> every result matches the SRL/SRA reference model, and the count of results equals the count of accepts.

Source files
------------

// File: rtl/shift_right_iterative.sv
// Multi-cycle right shifter (SRL/SRA), one bit position per clock.
// Operands enter and results leave through valid/ready handshakes.
module shift_right_iterative #(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in,
  input  logic [SW-1:0] shamt,
  input  logic          arith,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  data;
  logic [SW-1:0] count;
  logic          mode;
  logic          accept;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign out       = data;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (accept) state_nxt = (shamt != '0) ? SHIFT : DONE;
      SHIFT:
        if (count == SW'(1)) state_nxt = DONE;
      DONE:
        // Handoff and a fresh accept can share one edge: no idle bubble.
        if (out_ready) begin
          if (accept) state_nxt = (shamt != '0) ? SHIFT : DONE;
          else        state_nxt = IDLE;
        end
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      count <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data  <= in;
        count <= shamt;
        mode  <= arith;
      end else if (state == SHIFT) begin
        data  <= {mode & data[N-1], data[N-1:1]};
        count <= count - SW'(1);
      end
    end
  end

endmodule
